axi_demux_1xn_reg: RTL and testbench

AXI_DEMUX_1XN_REG -- requirements
Module: axi_demux_1xn_reg

---
 rtl/axi_demux_1xn_reg.sv | 125 ++++++++++++
 tb/tb_axi_demux_1xn_reg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_demux_1xn_reg.sv
// 1-to-N stream demultiplexer with burst route locking and a single
// shared holding register; bad destinations are swallowed with dec_err.
module axi_demux_1xn_reg #(
    parameter int DATA_W  = 32,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      enable,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_last,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic                      dec_err,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, LOCKED, DISCARD} state_t;

    localparam logic [31:0] NOUT = 32'(NUM_OUT);

    state_t            state;
    state_t            state_nxt;
    logic [SEL_W-1:0]  route_q;
    logic [SEL_W-1:0]  route_eff;
    logic [SEL_W-1:0]  dst;
    logic [DATA_W-1:0] hdata;
    logic              hlast;
    logic              hvalid;
    logic              bad;
    logic              dst_ready;
    logic              accept;
    logic              load;
    logic              drain;

    // Effective route: live select when idle, latched route inside a burst
    always_comb begin
        route_eff = (state == IDLE) ? in_sel : route_q;
        bad       = (state == DISCARD) || (32'(route_eff) >= NOUT);
    end

    // Ready of the lane currently holding the buffered beat
    always_comb begin
        dst_ready = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (32'(dst) == 32'(i)) dst_ready = out_ready[i];
        end
    end

    // Input handshake; discarded beats never wait on the holding register
    always_comb begin
        in_ready = ARESETN && enable && (bad || !hvalid || dst_ready);
        accept   = in_valid && in_ready;
        load     = accept && !bad;
        drain    = hvalid && dst_ready;
        busy     = (state != IDLE) || hvalid;
    end

    // Burst FSM next-state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && !in_last) state_nxt = bad ? DISCARD : LOCKED;
            end
            LOCKED, DISCARD: begin
                if (accept && in_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and latched burst route
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= IDLE;
            route_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept && !in_last) route_q <= in_sel;
        end
    end

    // Holding register: load wins over drain so back-to-back beats stream
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hvalid  <= 1'b0;
            hdata   <= '0;
            hlast   <= 1'b0;
            dst     <= '0;
            dec_err <= 1'b0;
        end else begin
            dec_err <= accept && bad;
            if (load) begin
                hvalid <= 1'b1;
                hdata  <= in_data;
                hlast  <= in_last;
                dst    <= route_eff;
            end else if (drain) begin
                hvalid <= 1'b0;
            end
        end
    end

    // Only the destination lane carries the held beat; others stay zero
    always_comb begin
        out_data  = '0;
        out_last  = '0;
        out_valid = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (hvalid && 32'(dst) == 32'(i)) begin
                out_valid[i]                 = 1'b1;
                out_last[i]                  = hlast;
                out_data[i*DATA_W +: DATA_W] = hdata;
            end
        end
    end

endmodule

// File: tb/tb_axi_demux_1xn_reg.sv
// Bench for axi_demux_1xn_reg: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_axi_demux_1xn_reg;

    localparam int DW = 32;
    localparam int N  = 3;
    localparam int SW = 2;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic [DW-1:0]   in_data;
    logic [SW-1:0]   in_sel;
    logic            in_last;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_last;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic            dec_err;
    logic            busy;

    int errors = 0;
    int checks = 0;

    axi_demux_1xn_reg #(.DATA_W(DW), .NUM_OUT(N), .SEL_W(SW)) dut (
        .ACLK      (clk),
        .ARESETN   (rst_n),
        .enable    (enable),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dec_err   (dec_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: one buffered beat plus "inside a burst to route r"
    logic          m_hv    = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic          m_last  = 1'b0;
    int            m_dst   = 0;
    logic          m_burst = 1'b0;
    int            m_broute = 0;
    logic          m_err   = 1'b0;

    function automatic int route_now();
        return m_burst ? m_broute : int'(in_sel);
    endfunction

    function automatic logic exp_ready();
        if (!rst_n || !enable) return 1'b0;
        if (route_now() >= N) return 1'b1;
        return !m_hv || out_ready[m_dst];
    endfunction

    function automatic logic acc_now();
        return in_valid && exp_ready();
    endfunction

    function automatic logic [N-1:0] exp_valid();
        exp_valid = '0;
        if (m_hv) exp_valid[m_dst] = 1'b1;
    endfunction

    function automatic logic [N-1:0] exp_last();
        exp_last = '0;
        if (m_hv) exp_last[m_dst] = m_last;
    endfunction

    function automatic logic [N*DW-1:0] exp_data();
        exp_data = '0;
        if (m_hv) exp_data[m_dst*DW +: DW] = m_data;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model update on each clock edge, cleared by async reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hv     <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            m_dst    <= 0;
            m_burst  <= 1'b0;
            m_broute <= 0;
            m_err    <= 1'b0;
        end else begin
            m_err <= acc_now() && route_now() >= N;
            if (acc_now() && route_now() < N) begin
                m_hv   <= 1'b1;
                m_data <= in_data;
                m_last <= in_last;
                m_dst  <= route_now();
            end else if (m_hv && out_ready[m_dst]) begin
                m_hv <= 1'b0;
            end
            if (acc_now()) begin
                if (!m_burst && !in_last) begin
                    m_burst  <= 1'b1;
                    m_broute <= int'(in_sel);
                end else if (m_burst && in_last) begin
                    m_burst <= 1'b0;
                end
            end
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        chk("in_ready", 128'(in_ready), 128'(exp_ready()));
        chk("out_valid", 128'(out_valid), 128'(exp_valid()));
        chk("out_last", 128'(out_last), 128'(exp_last()));
        chk("out_data", 128'(out_data), 128'(exp_data()));
        chk("dec_err", 128'(dec_err), 128'(m_err));
        chk("busy", 128'(busy), 128'(m_burst || m_hv));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [SW-1:0] s, input logic [DW-1:0] d,
                        input logic l);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        in_last  = l;
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        in_data   = '0;
        in_sel    = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = '1;
        step();
        step();
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        step();

        // single beat to lane 2
        beat(2'd2, 32'hA5A5A5A5, 1'b1);
        step();
        in_valid = 1'b0;
        chk("single_valid", 128'(out_valid), 128'(3'b100));
        chk("single_data", 128'(out_data), {32'h0, 32'hA5A5A5A5, 64'h0});
        chk("single_last", 128'(out_last), 128'(3'b100));
        step();

        // burst locked to lane 1
        beat(2'd1, 32'h11, 1'b0);
        step();
        chk("burst0", 128'(out_data[DW +: DW]), 128'(32'h11));
        beat(2'd3, 32'h22, 1'b0);
        step();
        chk("burst1", 128'(out_data[DW +: DW]), 128'(32'h22));
        chk("burst1_v", 128'(out_valid), 128'(3'b010));
        beat(2'd0, 32'h33, 1'b1);
        step();
        chk("burst2", 128'(out_data[DW +: DW]), 128'(32'h33));
        chk("burst2_l", 128'(out_last), 128'(3'b010));
        in_valid = 1'b0;
        step();
        chk("burst_idle", 128'(busy), 128'(0));

        // backpressure on lane 1
        out_ready = 3'b101;
        beat(2'd1, 32'hAAAA, 1'b1);
        step();
        beat(2'd1, 32'hBBBB, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", 128'(in_ready), 128'(0));
            chk("bp_hold", 128'(out_data[DW +: DW]), 128'(32'hAAAA));
            step();
        end
        out_ready = 3'b111;
        #1;
        chk("bp_release", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        chk("bp_next", 128'(out_data[DW +: DW]), 128'(32'hBBBB));
        chk("bp_next_v", 128'(out_valid), 128'(3'b010));
        step();

        // decode error burst to lane 3 (does not exist)
        beat(2'd3, 32'hDEAD, 1'b0);
        step();
        chk("derr_v0", 128'(out_valid), 128'(0));
        chk("derr_p0", 128'(dec_err), 128'(1));
        beat(2'd0, 32'hBEEF, 1'b1);
        step();
        in_valid = 1'b0;
        chk("derr_v1", 128'(out_valid), 128'(0));
        chk("derr_p1", 128'(dec_err), 128'(1));
        step();
        chk("derr_end", 128'(dec_err), 128'(0));
        chk("derr_idle", 128'(busy), 128'(0));
        beat(2'd0, 32'h77, 1'b1);
        step();
        in_valid = 1'b0;
        chk("derr_after", 128'(out_valid), 128'(3'b001));
        step();

        // enable low mid-burst keeps route
        beat(2'd2, 32'h100, 1'b0);
        step();
        enable = 1'b0;
        beat(2'd0, 32'h200, 1'b0);
        #1;
        chk("en_ready", 128'(in_ready), 128'(0));
        step();
        chk("en_drain", 128'(out_valid), 128'(0));
        chk("en_busy", 128'(busy), 128'(1));
        enable = 1'b1;
        step();
        chk("en_route", 128'(out_valid), 128'(3'b100));
        chk("en_data", 128'(out_data[2*DW +: DW]), 128'(32'h200));

        // reset mid-burst
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 128'(out_valid), 128'(0));
        chk("mrst_data", 128'(out_data), 128'(0));
        chk("mrst_ready", 128'(in_ready), 128'(0));
        chk("mrst_busy", 128'(busy), 128'(0));
        step();
        rst_n = 1'b1;
        beat(2'd0, 32'h300, 1'b1);
        step();
        in_valid = 1'b0;
        chk("mrst_lane0", 128'(out_valid), 128'(3'b001));
        step();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 2'($urandom_range(0, 3));
            in_last   = ($urandom_range(0, 2) == 0);
            in_data   = $urandom;
            out_ready = 3'($urandom);
            rst_n     = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
